pipelined_ripple_adder: RTL
===========================

// Module: pipelined_ripple_adder
// PURPOSE
//  Parametrised, pipelined successor to the team's 16-bit combinational ripple adder.
//  Splits a WIDTH-bit add/subtract into STAGES ripple segments, with one register stage per segment.
//  Carry moves between segments through pipeline registers, so clock period scales with WIDTH/STAGES.
//  Valid/ready handshake on both sides with full backpressure. Sits in datapath/synthesis labs as the timing-driven adder.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be an integer multiple of STAGES
//  STAGES  4   pipeline depth = number of ripple segments; 1 <= STAGES <= WIDTH
// PORTS
//  CLK        in   1      single clock, rising edge
//  RST        in   1      synchronous, active-high reset
//  in_valid   in   1      A/B/Cin/Sub valid this cycle
//  in_ready   out  1      pipeline can accept this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  Cin        in   1      carry-in (add mode only)
//  Sub        in   1      0: A+B+Cin ; 1: A-B (A+~B+1, Cin ignored)
//  out_valid  out  1      Sum/Cout/Ovf valid
//  out_ready  in   1      downstream accepts result
//  Sum        out  WIDTH  result, low WIDTH bits
//  Cout       out  1      carry out of MSB (Sub=1: 1 means no borrow, i.e. A>=B unsigned)
//  Ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset: at the first CLK edge with RST=1, all valid bits, Sum, Cout, Ovf and the carry/skew registers clear to 0. in_ready=1 once RST is low.
//  - Segment width SEG=WIDTH/STAGES. Stage k (0..STAGES-1) ripples bits [k*SEG +: SEG] using the carry registered by stage k-1.
//    Stage 0 uses the effective carry-in: Sub ? 1 : Cin.
//  - Operand B is inverted on entry when Sub=1. Upper operand segments travel through skew registers.
//    Lower result segments travel through de-skew registers, so every bit of one transaction exits together.
//  - Advance: adv = ~out_valid | out_ready. in_ready = adv, combinational.
//    When adv=1, every stage, including its valid bit, shifts one position.
//    When adv=0, every register holds.
//  - Transfer: the input is accepted on a cycle with in_valid & in_ready. The output is consumed on a cycle with out_valid & out_ready.
//  - Latency: exactly STAGES cycles from acceptance to out_valid when adv stays 1. Throughput is 1 per cycle.
//  - Bubbles: pipeline valid bits shift with the data. Bubbles are not collapsed under stall.
//    A stall freezes bubbles as well as valid data.
//  - Output stability: while out_valid=1 and out_ready=0, Sum/Cout/Ovf/out_valid hold constant.
//  - Simultaneous accept and drain when full: legal, no data lost, throughput unchanged.
//  - Wrap-around: arithmetic is modulo 2^WIDTH. The overflowed bit appears only on Cout. Ovf is computed per signed two's-complement rules.
//  - Reset mid-operation: RST=1 discards all in-flight data on that edge. out_valid=0 the next cycle, and no partial result is ever emitted.
//  - When STAGES=1 the block is a single registered ripple adder with handshake, latency 1.
//  - Sum/Cout/Ovf are don't-care when out_valid=0, but must not be X after reset.
// TESTING (WIDTH=16, STAGES=4 unless noted)
//  1 Reset, then A=16'h1234, B=16'h0FED, Cin=0, Sub=0, one beat, out_ready=1
//    -> out_valid exactly 4 cycles later, Sum=16'h2221, Cout=0, Ovf=0.
//  2 A=16'hFFFF, B=16'h0001, Cin=1, Sub=0
//    -> Sum=16'h0001, Cout=1, Ovf=0. Then A=16'h7FFF, B=16'h0001, Cin=0 -> Sum=16'h8000, Cout=0, Ovf=1.
//  3 Sub=1: A=16'h0005, B=16'h0007, Cin=1 -> Sum=16'hFFFE, Cout=0, Ovf=0.
//    Then A=16'h8000, B=16'h0001 -> Sum=16'h7FFF, Cout=1, Ovf=1.
//  4 Stream 8 back-to-back random beats, with out_ready held 0 for cycles 5-7 after the first accept
//    -> in_ready=0 during the stall, outputs held stable, all 8 results match the reference model in order, none dropped or duplicated.
//  5 Assert RST for 1 cycle while 3 beats are in flight -> out_valid=0 the next cycle, none of the 3 results ever appears.
//    A new beat accepted afterwards emerges after 4 cycles.
//  6 Re-run scenarios 1-4 with STAGES=1 and STAGES=16, and with WIDTH=32, STAGES=8
//    -> latency equals STAGES, and 10k random vectors (exhaustive over carry-chain corner patterns) match the model.

Source files
------------

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor.
// A WIDTH-bit add (or subtract, via B inversion and carry-in of 1) is split
// into STAGES ripple segments of SEG = WIDTH/STAGES bits. Each segment has one
// register stage. Upper operand bits travel forward in skew registers until
// their segment is reached. Finished low result bits travel forward in
// de-skew registers, so a whole result leaves the last stage together.
//
// Handshake: a beat is accepted when in_valid & in_ready, and delivered when
// out_valid & out_ready. The whole pipe advances as one unit when
// adv = ~out_valid | out_ready. Otherwise every register holds, and bubbles
// are held as well. in_ready equals adv and is combinational.
module pipelined_ripple_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int SEG = WIDTH / STAGES;

  // Per-stage registers: operands, partial sum, segment carry-out, valid
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;

  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] v_d;
  logic              ovf_d;

  logic adv;

  assign adv       = ~v_q[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign Sum       = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign Ovf       = ovf_q;

  // Each stage ripples its own segment, using the carry registered by the stage before it
  always_comb begin : stage_logic
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_run;
    logic             c_msb;
    logic             v_in;
    int               kp;
    a_in  = '0;
    b_in  = '0;
    s_in  = '0;
    c_run = 1'b0;
    c_msb = 1'b0;
    v_in  = 1'b0;
    kp    = 0;
    c_d   = '0;
    v_d   = '0;
    ovf_d = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      kp = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        // Entry: B is inverted for subtract. The effective carry-in is forced to 1 for subtract.
        a_in  = A;
        b_in  = Sub ? ~B : B;
        s_in  = '0;
        c_run = Sub | Cin;
        v_in  = in_valid;
      end else begin
        a_in  = a_q[kp];
        b_in  = b_q[kp];
        s_in  = s_q[kp];
        c_run = c_q[kp];
        v_in  = v_q[kp];
      end
      for (int j = 0; j < SEG; j++) begin
        // c_msb ends up holding the carry into the top bit after the final stage
        c_msb = c_run;
        s_in[k*SEG+j] = a_in[k*SEG+j] ^ b_in[k*SEG+j] ^ c_run;
        c_run = (a_in[k*SEG+j] & b_in[k*SEG+j]) |
                (c_run & (a_in[k*SEG+j] ^ b_in[k*SEG+j]));
      end
      a_d[k] = a_in;
      b_d[k] = b_in;
      s_d[k] = s_in;
      c_d[k] = c_run;
      v_d[k] = v_in;
    end
    ovf_d = c_msb ^ c_d[STAGES-1];
  end

  // Pipeline registers: clear on reset, shift together on adv, otherwise hold
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

endmodule
